// File: rtl/pizza_pkg.sv
// Shared constants, thickness encoding and classification helper for the pizza order datapath.
package pizza_pkg;

  localparam logic [2:0] TuzSiniri     = 3'd5;
  localparam logic [5:0] KalinEsikAlt  = 6'd32;
  localparam logic [5:0] KalinEsikUst  = 6'd56;
  localparam logic [6:0] SayiTavan     = 7'd100;
  localparam logic [3:0] MalzemeSoslu  = 4'd7;
  localparam logic [3:0] MalzemeSossuz = 4'd6;

  typedef enum logic [1:0] {
    KalinInce  = 2'd0,
    KalinOrta  = 2'd1,
    KalinKalin = 2'd2
  } kalinlik_e;

  // Encoding 3 is unreachable by construction.
  function automatic kalinlik_e kalinlik_sinifi(input logic [5:0] un);
    if (un >= KalinEsikUst) begin
      return KalinKalin;
    end else if (un >= KalinEsikAlt) begin
      return KalinOrta;
    end
    return KalinInce;
  endfunction

endpackage

// File: rtl/pizza_if.sv
// Order/result bundle for driving and observing a pizza block.
interface pizza_if;

  logic       reset;
  logic [5:0] un_miktari;
  logic [7:0] su_miktari;
  logic [2:0] tuz_miktari;
  logic       maya;
  logic       sos;
  logic [1:0] kalinlik;
  logic       secilen_malzeme;
  logic [3:0] malzeme_miktari;
  logic       kabarik;
  logic       tuzlu;
  logic [6:0] pizza_sayisi;

  modport master (
    output reset, un_miktari, su_miktari, tuz_miktari, maya, sos,
    input  kalinlik, secilen_malzeme, malzeme_miktari, kabarik, tuzlu, pizza_sayisi
  );

  modport slave (
    input  reset, un_miktari, su_miktari, tuz_miktari, maya, sos,
    output kalinlik, secilen_malzeme, malzeme_miktari, kabarik, tuzlu, pizza_sayisi
  );

endinterface

// File: rtl/pizza_sayac.sv
// 7-bit saturating up-counter with enable and synchronous active-low clear.
module pizza_sayac
  import pizza_pkg::*;
(
  input  logic       saat,
  input  logic       reset,
  input  logic       en,
  output logic [6:0] sayi
);

  logic [6:0] sayi_d;

  always_comb begin
    sayi_d = sayi;
    if (en && (sayi < SayiTavan)) begin
      sayi_d = sayi + 7'd1;
    end
  end

  always_ff @(posedge saat) begin
    if (!reset) begin
      sayi <= '0;
    end else begin
      sayi <= sayi_d;
    end
  end

endmodule

// File: rtl/pizza.sv
// Pizza order evaluator: classifies each sampled order and registers the result one cycle later.
module pizza
  import pizza_pkg::*;
(
  input  logic       saat,
  input  logic       reset,
  input  logic [5:0] un_miktari,
  input  logic [7:0] su_miktari,
  input  logic [2:0] tuz_miktari,
  input  logic       maya,
  input  logic       sos,
  output logic [1:0] kalinlik,
  output logic       secilen_malzeme,
  output logic [3:0] malzeme_miktari,
  output logic       kabarik,
  output logic       tuzlu,
  output logic [6:0] pizza_sayisi
);

  kalinlik_e  kalinlik_d;
  logic       tuzlu_d;
  logic       kabarik_d;
  logic [3:0] malzeme_d;

  // Water amount is accepted but has no effect on the result.
  logic unused_su;
  assign unused_su = ^su_miktari;

  always_comb begin
    tuzlu_d    = (tuz_miktari >= TuzSiniri);
    kalinlik_d = kalinlik_sinifi(un_miktari);
    kabarik_d  = 1'b0;
    malzeme_d  = 4'd0;
    if (!tuzlu_d) begin
      kabarik_d = maya;
      malzeme_d = sos ? MalzemeSoslu : MalzemeSossuz;
    end
  end

  always_ff @(posedge saat) begin
    if (!reset) begin
      kalinlik        <= '0;
      secilen_malzeme <= 1'b0;
      malzeme_miktari <= '0;
      kabarik         <= 1'b0;
      tuzlu           <= 1'b0;
    end else begin
      kalinlik        <= kalinlik_d;
      secilen_malzeme <= 1'b1;
      malzeme_miktari <= malzeme_d;
      kabarik         <= kabarik_d;
      tuzlu           <= tuzlu_d;
    end
  end

  pizza_sayac u_sayac (
    .saat (saat),
    .reset(reset),
    .en   (!tuzlu_d),
    .sayi (pizza_sayisi)
  );

endmodule

// File: tb/tb_pizza.sv
// Self-checking bench for pizza: reference model feeds a scoreboard, plus table and sequence checks.
module tb_pizza;

  logic saat = 1'b0;
  always #5 saat = ~saat;

  pizza_if pif ();

  pizza dut (
    .saat           (saat),
    .reset          (pif.reset),
    .un_miktari     (pif.un_miktari),
    .su_miktari     (pif.su_miktari),
    .tuz_miktari    (pif.tuz_miktari),
    .maya           (pif.maya),
    .sos            (pif.sos),
    .kalinlik       (pif.kalinlik),
    .secilen_malzeme(pif.secilen_malzeme),
    .malzeme_miktari(pif.malzeme_miktari),
    .kabarik        (pif.kabarik),
    .tuzlu          (pif.tuzlu),
    .pizza_sayisi   (pif.pizza_sayisi)
  );

  typedef struct packed {
    logic [1:0] kal;
    logic       sec;
    logic [3:0] malz;
    logic       kab;
    logic       tuz;
    logic [6:0] cnt;
  } out_t;

  typedef struct {
    logic [5:0] un;
    logic [2:0] tuz;
    logic       maya;
    logic       sos;
    logic [1:0] kal;
    logic [3:0] malz;
    logic       kab;
    logic       tuzlu;
  } vec_t;

  out_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_cnt  = 0;
  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, req);
    end
  endtask

  // Drive one order, predict its result, then compare after the edge.
  task automatic step(input logic rst, input logic [5:0] un, input logic [2:0] tuz,
                      input logic my, input logic ss);
    out_t e;
    out_t got;
    pif.reset       = rst;
    pif.un_miktari  = un;
    pif.su_miktari  = 8'($urandom);
    pif.tuz_miktari = tuz;
    pif.maya        = my;
    pif.sos         = ss;
    e = '0;
    if (!rst) begin
      m_cnt = 0;
    end else begin
      e.sec = 1'b1;
      e.kal = (un < 32) ? 2'd0 : (un < 56) ? 2'd1 : 2'd2;
      if (tuz >= 5) begin
        e.tuz = 1'b1;
      end else begin
        e.kab  = my;
        e.malz = ss ? 4'd7 : 4'd6;
        if (m_cnt < 100) m_cnt++;
      end
      e.cnt = 7'(m_cnt);
    end
    exp_q.push_back(e);
    @(posedge saat);
    #1;
    got = {pif.kalinlik, pif.secilen_malzeme, pif.malzeme_miktari, pif.kabarik, pif.tuzlu,
           pif.pizza_sayisi};
    if (exp_q.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("kalinlik", got.kal, e.kal);
      chk("secilen_malzeme", got.sec, e.sec);
      chk("malzeme_miktari", got.malz, e.malz);
      chk("kabarik", got.kab, e.kab);
      chk("tuzlu", got.tuz, e.tuz);
      chk("pizza_sayisi", got.cnt, e.cnt);
    end
  endtask

  task automatic do_reset();
    step(1'b0, 6'd0, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    vecs[0] = '{6'd31, 3'd0, 1'b0, 1'b0, 2'd0, 4'd6, 1'b0, 1'b0};
    vecs[1] = '{6'd32, 3'd1, 1'b1, 1'b0, 2'd1, 4'd6, 1'b1, 1'b0};
    vecs[2] = '{6'd55, 3'd4, 1'b0, 1'b1, 2'd1, 4'd7, 1'b0, 1'b0};
    vecs[3] = '{6'd56, 3'd5, 1'b1, 1'b1, 2'd2, 4'd0, 1'b0, 1'b1};
    vecs[4] = '{6'd63, 3'd7, 1'b1, 1'b0, 2'd2, 4'd0, 1'b0, 1'b1};
    vecs[5] = '{6'd0,  3'd4, 1'b1, 1'b1, 2'd0, 4'd7, 1'b1, 1'b0};
    vecs[6] = '{6'd40, 3'd3, 1'b0, 1'b0, 2'd1, 4'd6, 1'b0, 1'b0};
    vecs[7] = '{6'd57, 3'd6, 1'b0, 1'b1, 2'd2, 4'd0, 1'b0, 1'b1};

    pif.reset = 1'b0;
    pif.un_miktari = '0;
    pif.su_miktari = '0;
    pif.tuz_miktari = '0;
    pif.maya = 1'b0;
    pif.sos = 1'b0;

    // Reset state
    do_reset();
    chk("rst_cnt", pif.pizza_sayisi, 0);
    chk("rst_sec", pif.secilen_malzeme, 0);

    // Two valid thick orders
    repeat (2) step(1'b1, 6'd63, 3'd4, 1'b1, 1'b1);
    chk("r17_kal", pif.kalinlik, 2);
    chk("r17_malz", pif.malzeme_miktari, 7);
    chk("r17_cnt", pif.pizza_sayisi, 2);

    // Long salty run never counts
    do_reset();
    repeat (300) step(1'b1, 6'd63, 3'd7, 1'b1, 1'b1);
    chk("r18_tuzlu", pif.tuzlu, 1);
    chk("r18_cnt", pif.pizza_sayisi, 0);
    chk("r18_kal", pif.kalinlik, 2);

    // Mixed run; salty gap must not stall counting
    do_reset();
    repeat (20) step(1'b1, 6'd23, 3'd2, 1'b1, 1'b0);
    repeat (20) step(1'b1, 6'd55, 3'd3, 1'b0, 1'b0);
    repeat (4) step(1'b1, 6'd23, 3'd6, 1'b1, 1'b1);
    chk("r19_salty_cnt", pif.pizza_sayisi, 40);
    repeat (3) step(1'b1, 6'd20, 3'd0, 1'b1, 1'b1);
    chk("r19_cnt", pif.pizza_sayisi, 43);
    chk("r19_kab", pif.kabarik, 1);
    chk("r19_malz", pif.malzeme_miktari, 7);

    // Saturation at 100
    do_reset();
    repeat (88) step(1'b1, 6'd12, 3'd4, 1'b1, 1'b0);
    chk("r20_start", pif.pizza_sayisi, 88);
    repeat (56) step(1'b1, 6'd12, 3'd4, 1'b1, 1'b0);
    chk("r20_cnt", pif.pizza_sayisi, 100);
    chk("r20_malz", pif.malzeme_miktari, 6);

    // Table: thickness boundaries and salt threshold
    for (int i = 0; i < 8; i++) begin
      step(1'b1, vecs[i].un, vecs[i].tuz, vecs[i].maya, vecs[i].sos);
      chk($sformatf("tbl%0d_kal", i), pif.kalinlik, vecs[i].kal);
      chk($sformatf("tbl%0d_malz", i), pif.malzeme_miktari, vecs[i].malz);
      chk($sformatf("tbl%0d_kab", i), pif.kabarik, vecs[i].kab);
      chk($sformatf("tbl%0d_tuzlu", i), pif.tuzlu, vecs[i].tuzlu);
    end
    chk("tbl_cnt_sat", pif.pizza_sayisi, 100);

    // Reset wins over a valid order on the same edge
    step(1'b0, 6'd63, 3'd0, 1'b1, 1'b1);
    chk("r22_rst_cnt", pif.pizza_sayisi, 0);
    chk("r22_rst_malz", pif.malzeme_miktari, 0);
    step(1'b1, 6'd63, 3'd0, 1'b1, 1'b1);
    chk("r22_cnt", pif.pizza_sayisi, 1);

    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual running required finished");
    $fatal(1);
  end

endmodule
